// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_pkg
// Purpose  : Shared size encodings, FSM state codes and lane helper functions
//            for the memory access unit.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    // Access size encodings as carried on req_size
    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // FSM state codes
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_BEAT0 = 2'd1;
    localparam state_t ST_BEAT1 = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    // Byte-lane strobe for an access starting at lane 0
    function automatic logic [3:0] base_strobe(input logic [1:0] size);
        logic [3:0] strb;
        case (size)
            SZ_BYTE: strb = 4'b0001;
            SZ_HALF: strb = 4'b0011;
            SZ_WORD: strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    // Number of bytes moved by an access; illegal size moves nothing
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] nb;
        case (size)
            SZ_BYTE: nb = 3'd1;
            SZ_HALF: nb = 3'd2;
            SZ_WORD: nb = 3'd4;
            default: nb = 3'd0;
        endcase
        return nb;
    endfunction

    // Mask right-justified load data to the access size, then extend
    function automatic logic [31:0] load_extend(input logic [31:0] data,
                                                input logic [1:0]  size,
                                                input logic        is_unsigned);
        logic [31:0] res;
        case (size)
            SZ_BYTE: res = is_unsigned ? {24'h0, data[7:0]}
                                       : {{24{data[7]}}, data[7:0]};
            SZ_HALF: res = is_unsigned ? {16'h0, data[15:0]}
                                       : {{16{data[15]}}, data[15:0]};
            SZ_WORD: res = data;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Combinational lane steering. Positions store data and strobes
//            across the two possible beats and rebuilds load data from the
//            low/high beat captures.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [3:0]  strb_lo,
    output logic [3:0]  strb_hi,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] rdata,
    output logic        split,
    output logic        misaligned
);

    logic [7:0]  w_strb8;
    logic [63:0] w_wide;
    logic [31:0] w_merged;
    logic [2:0]  w_nbytes;
    logic [1:0]  w_nb_mask;

    // Shift strobes and data up by the byte offset; the upper half belongs
    // to the second beat. Loads shift the two captured words back down.
    always_comb begin
        w_nbytes   = size_bytes(size);
        w_nb_mask  = w_nbytes[1:0] - 2'd1;
        w_strb8    = {4'b0000, base_strobe(size)} << off;
        w_wide     = {32'h0, wdata} << {off, 3'b000};
        w_merged   = 32'({hi, lo} >> {off, 3'b000});
        strb_lo    = w_strb8[3:0];
        strb_hi    = w_strb8[7:4];
        wdata_lo   = w_wide[31:0];
        wdata_hi   = w_wide[63:32];
        rdata      = load_extend(w_merged, size, is_unsigned);
        split      = (({1'b0, off} + w_nbytes) > 3'd4);
        // Natural alignment: offset must be a multiple of the access size
        misaligned = ((off & w_nb_mask) != 2'b00);
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Single-outstanding load/store initiator onto a word-wide,
//            byte-strobed SRAM. Splits word-crossing accesses into two beats
//            and returns aligned, extended load data.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ALLOW_MISALIGNED = 1,
    parameter int ADDR_W           = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              MemRead,
    output logic [3:0]        MemWrite,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       write_data,
    input  logic [31:0]       read_data
);

    // Latched request and beat captures
    state_t            r_state;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [ADDR_W-1:0] r_addr_al;
    logic [1:0]        r_off;
    logic [31:0]       r_wdata;
    logic [31:0]       r_lo;
    logic [31:0]       r_hi;
    logic              r_err;

    // Lane-align operands: live request while idle, latched request after
    logic              w_idle;
    logic              w_accept;
    logic              w_req_err;
    logic [ADDR_W-1:0] w_req_al;
    logic [1:0]        w_off;
    logic [1:0]        w_size;
    logic              w_unsigned;
    logic [31:0]       w_wdata;
    logic [3:0]        w_strb_lo;
    logic [3:0]        w_strb_hi;
    logic [31:0]       w_wdata_lo;
    logic [31:0]       w_wdata_hi;
    logic [31:0]       w_rdata;
    logic              w_split;
    logic              w_misaligned;

    // Select lane-align operands and decode the incoming request
    always_comb begin
        w_idle     = (r_state == ST_IDLE);
        w_off      = w_idle ? req_addr[1:0] : r_off;
        w_size     = w_idle ? req_size      : r_size;
        w_unsigned = w_idle ? req_unsigned  : r_unsigned;
        w_wdata    = w_idle ? req_wdata     : r_wdata;
        w_accept   = req_valid && req_ready;
        w_req_al   = {req_addr[ADDR_W-1:2], 2'b00};
        w_req_err  = (req_size == SZ_ILLEGAL) ||
                     ((ALLOW_MISALIGNED == 0) && w_misaligned);
    end

    mem_lane_align u_lane_align (
        .off         (w_off),
        .size        (w_size),
        .is_unsigned (w_unsigned),
        .wdata       (w_wdata),
        .lo          (r_lo),
        .hi          (r_hi),
        .strb_lo     (w_strb_lo),
        .strb_hi     (w_strb_hi),
        .wdata_lo    (w_wdata_lo),
        .wdata_hi    (w_wdata_hi),
        .rdata       (w_rdata),
        .split       (w_split),
        .misaligned  (w_misaligned)
    );

    // Request FSM; every output is registered and defaults to idle values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_write    <= 1'b0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_addr_al  <= '0;
            r_off      <= 2'b00;
            r_wdata    <= 32'h0;
            r_lo       <= 32'h0;
            r_hi       <= 32'h0;
            r_err      <= 1'b0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 32'h0;
            MemRead    <= 1'b0;
            MemWrite   <= 4'b0000;
            address    <= '0;
            write_data <= 32'h0;
        end else begin
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 32'h0;
            MemRead    <= 1'b0;
            MemWrite   <= 4'b0000;
            address    <= '0;
            write_data <= 32'h0;
            case (r_state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (w_accept) begin
                        req_ready  <= 1'b0;
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr_al  <= w_req_al;
                        r_off      <= req_addr[1:0];
                        r_wdata    <= req_wdata;
                        r_lo       <= 32'h0;
                        r_hi       <= 32'h0;
                        r_err      <= w_req_err;
                        if (w_req_err) begin
                            // Errors skip the SRAM entirely
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_BEAT0;
                            address <= w_req_al;
                            MemRead <= !req_write;
                            if (req_write) begin
                                MemWrite   <= w_strb_lo;
                                write_data <= w_wdata_lo;
                            end
                        end
                    end
                end
                ST_BEAT0: begin
                    if (!r_write) begin
                        r_lo <= read_data;
                    end
                    if (w_split) begin
                        r_state <= ST_BEAT1;
                        address <= r_addr_al + ADDR_W'(4);
                        MemRead <= !r_write;
                        if (r_write) begin
                            MemWrite   <= w_strb_hi;
                            write_data <= w_wdata_hi;
                        end
                    end else begin
                        r_state <= ST_RESP;
                    end
                end
                ST_BEAT1: begin
                    if (!r_write) begin
                        r_hi <= read_data;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= r_err;
                    rsp_rdata <= (r_write || r_err) ? 32'h0 : w_rdata;
                    req_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench. dut_a (split allowed) talks to a
//            byte-array SRAM; dut_b (split disallowed) shares the request
//            inputs and is checked on the misaligned-error case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_MemRead;
    logic [31:0] a_rsp_rdata, a_address, a_write_data, a_read_data;
    logic [3:0]  a_MemWrite;

    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_MemRead;
    logic [31:0] b_rsp_rdata, b_address, b_write_data, b_read_data;
    logic [3:0]  b_MemWrite;

    logic [7:0]  mem [0:1023] = '{default: 8'h00};
    logic [9:0]  a_idx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_access_unit #(.ALLOW_MISALIGNED(1), .ADDR_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(a_req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .MemRead(a_MemRead), .MemWrite(a_MemWrite),
        .address(a_address), .write_data(a_write_data), .read_data(a_read_data)
    );

    mem_access_unit #(.ALLOW_MISALIGNED(0), .ADDR_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(b_req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .MemRead(b_MemRead), .MemWrite(b_MemWrite),
        .address(b_address), .write_data(b_write_data), .read_data(b_read_data)
    );

    // SRAM model for dut_a: combinational read, byte-strobed write
    assign a_idx       = a_address[9:0];
    assign a_read_data = a_MemRead ? {mem[a_idx + 10'd3], mem[a_idx + 10'd2],
                                      mem[a_idx + 10'd1], mem[a_idx]} : 32'h0;
    assign b_read_data = 32'h5A5A5A5A;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (a_MemWrite[i]) mem[10'(a_idx + 10'(i))] <= a_write_data[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request and return #1 after its acceptance edge
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        chk("ready_before_req", 32'(a_req_ready), 32'd1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acc_cyc   = cyc;
    endtask

    task automatic chk_beat(input string tag, input logic rd, input logic [3:0] we,
                            input logic [31:0] addr, input logic [31:0] wd);
        chk({tag, "_rd_we"}, 32'({a_MemRead, a_MemWrite}), 32'({rd, we}));
        chk({tag, "_addr"}, a_address, addr);
        chk({tag, "_wdata"}, a_write_data, wd);
    endtask

    // Wait (bounded) for dut_a's response, then check it and the 1-cycle pulse
    task automatic wait_rsp(input string tag, input int lat,
                            input logic [31:0] rdata, input logic err);
        int n = 0;
        while (a_rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_valid"}, 32'(a_rsp_valid), 32'd1);
        chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(lat));
        chk({tag, "_rdata"}, a_rsp_rdata, rdata);
        chk({tag, "_err"}, 32'(a_rsp_err), 32'(err));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 32'(a_rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        #12;
        chk("reset_ctrl", 32'({a_req_ready, a_rsp_valid, a_rsp_err, a_MemRead, a_MemWrite}), 32'h80);
        chk("reset_addr", a_address, 32'h0);
        chk("reset_wdata", a_write_data, 32'h0);
        chk("reset_rdata", a_rsp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Byte store of 0x80 to 0x103: lane 3
        issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h00000080);
        chk("sb_busy", 32'(a_req_ready), 32'd0);
        chk_beat("sb_beat", 1'b0, 4'b1000, 32'h100, 32'h80000000);
        wait_rsp("sb", 2, 32'h0, 1'b0);

        // Signed and unsigned byte load at 0x103
        issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
        chk_beat("lb_beat", 1'b1, 4'b0000, 32'h100, 32'h0);
        wait_rsp("lb_s", 2, 32'hFFFFFF80, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
        wait_rsp("lb_u", 2, 32'h00000080, 1'b0);

        // Aligned word store then load at 0x100
        issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        chk_beat("sw_beat", 1'b0, 4'b1111, 32'h100, 32'hDEADBEEF);
        wait_rsp("sw", 2, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        chk_beat("lw_beat", 1'b1, 4'b0000, 32'h100, 32'h0);
        wait_rsp("lw", 2, 32'hDEADBEEF, 1'b0);

        // Half store at 0x102, then half loads and a byte load next to it
        issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000A55A);
        chk_beat("sh_beat", 1'b0, 4'b1100, 32'h100, 32'hA55A0000);
        wait_rsp("sh", 2, 32'h0, 1'b0);
        issue(1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
        wait_rsp("lhu", 2, 32'h0000A55A, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
        wait_rsp("lh_s", 2, 32'hFFFFA55A, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h101, 32'h0);
        wait_rsp("lb_101", 2, 32'hFFFFFFBE, 1'b0);

        // Split word store at 0x201
        issue(1'b1, 2'b10, 1'b0, 32'h201, 32'h11223344);
        chk_beat("ssw_b0", 1'b0, 4'b1110, 32'h200, 32'h22334400);
        @(posedge clk);
        #1;
        chk_beat("ssw_b1", 1'b0, 4'b0001, 32'h204, 32'h00000011);
        wait_rsp("ssw", 3, 32'h0, 1'b0);

        // Split word load at 0x201
        issue(1'b0, 2'b10, 1'b0, 32'h201, 32'h0);
        chk_beat("slw_b0", 1'b1, 4'b0000, 32'h200, 32'h0);
        @(posedge clk);
        #1;
        chk_beat("slw_b1", 1'b1, 4'b0000, 32'h204, 32'h0);
        wait_rsp("slw", 3, 32'h11223344, 1'b0);

        // Signed half crossing the boundary at 0x203: bytes 0x22, 0x11
        issue(1'b0, 2'b01, 1'b0, 32'h203, 32'h0);
        wait_rsp("slh", 3, 32'h00001122, 1'b0);

        // Misaligned word load at 0x002: dut_b errors, dut_a splits
        issue(1'b0, 2'b10, 1'b0, 32'h002, 32'h0);
        chk("mis_b_noread0", 32'({b_MemRead, b_MemWrite}), 32'h0);
        chk("mis_b_early", 32'(b_rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("mis_b_valid", 32'(b_rsp_valid), 32'd1);
        chk("mis_b_err", 32'(b_rsp_err), 32'd1);
        chk("mis_b_rdata", b_rsp_rdata, 32'h0);
        chk("mis_b_noread1", 32'(b_MemRead), 32'd0);
        wait_rsp("mis_a", 3, 32'h0, 1'b0);

        // Illegal size with splitting allowed
        issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
        chk("ill_noaccess", 32'({a_MemRead, a_MemWrite}), 32'h0);
        wait_rsp("ill", 1, 32'h0, 1'b1);

        // Reset during the second beat of a split store at 0x302
        issue(1'b1, 2'b10, 1'b0, 32'h302, 32'hAABBCCDD);
        chk_beat("rst_b0", 1'b0, 4'b1100, 32'h300, 32'hCCDD0000);
        @(posedge clk);
        #1;
        chk_beat("rst_b1", 1'b0, 4'b0011, 32'h304, 32'h0000AABB);
        rst_n = 1'b0;
        #1;
        chk("rst_async_ctrl", 32'({a_req_ready, a_rsp_valid, a_rsp_err, a_MemRead, a_MemWrite}), 32'h80);
        chk("rst_async_addr", a_address, 32'h0);
        chk("rst_async_wdata", a_write_data, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mem", {mem[10'h305], mem[10'h304], mem[10'h303], mem[10'h302]}, 32'h0000CCDD);
        chk("rst_no_rsp", 32'(a_rsp_valid), 32'd0);

        // Normal operation after the abort
        issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        chk_beat("post_beat", 1'b1, 4'b0000, 32'h300, 32'h0);
        wait_rsp("post", 2, 32'hCCDD0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
